rsa_modexp: RTL and testbench
=============================

# rsa_modexp

Bit-serial modular exponentiation core (out = in^e mod n) that sits directly downstream of the RSA enable/sequencing FSM. It consumes that FSM's `en_rsa`/`clear_rsa` controls and returns the `eoc_rsa` end-of-conversion flag that drives its IRQ state. Exponentiation is left-to-right square-and-multiply over an interleaved (Blakley) modular multiplier. Latency is deterministic and depends only on WIDTH and the exponent.

## Interface
- WIDTH, 8, operand/modulus/exponent width in bits (≥2)
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- ena  input  1  global enable; when low all registers hold (rst still acts)
- en_rsa  input  1  run enable from sequencer; low = hold (freeze) in place
- clear_rsa  input  1  active-low synchronous clear; low = return to IDLE, eoc low
- in_data  input  WIDTH  message/ciphertext m, sampled in LOAD
- exponent  input  WIDTH  exponent e, sampled in LOAD
- modulus  input  WIDTH  modulus n, sampled in LOAD
- out_data  output  WIDTH  result register, reset 0
- eoc_rsa  output  1  end of conversion, high in DONE only, reset 0

## Operation
- Priority per clock (when ena=1): clear_rsa=0 → state IDLE, eoc_rsa=0, multiplier aborted; else en_rsa=0 → hold all registers; else advance FSM.
- out_data is written only on entering DONE; it survives clear_rsa and is cleared only by rst.
- FSM states: IDLE, LOAD, SQ_START, SQ_WAIT, MUL_START, MUL_WAIT, NEXT, DONE.
- IDLE: when advancing (en_rsa=1, clear_rsa=1) → LOAD.
- LOAD: latch in_data, exponent, modulus; acc=1; idx=WIDTH-1 → SQ_START.
- SQ_START: issue mm_start with a=b=acc → SQ_WAIT.
- SQ_WAIT: on mm_done, acc=product; → MUL_START if e[idx] else NEXT.
- MUL_START: issue mm_start with a=acc, b=m → MUL_WAIT.
- MUL_WAIT: on mm_done, acc=product → NEXT.
- NEXT: if idx==0 → DONE (out_data=acc), else idx-1 → SQ_START.
- DONE: eoc_rsa=1; stay until clear_rsa=0.
- Multiplier (Blakley): P=0; for i=WIDTH-1..0: P=2P + a[i]·b, then up to two conditional subtracts of n. Internal width WIDTH+2 bits, no overflow for a,b<n.
- Valid range: 2 ≤ n, in_data < n. Outside it the result is undefined, but latency and termination are unchanged (no hang, including n=0).
- e=0 gives out_data=1.

## Timing
- Multiplier: mm_start sampled at cycle s; iterations occur at s+1..s+WIDTH; mm_done pulses at s+WIDTH+1 with product valid. Each operation costs WIDTH+2 FSM cycles.
- DONE is first entered L + 1 + WIDTH·(WIDTH+3) + popcount(e)·(WIDTH+2) cycles after LOAD cycle L (macro off).
- eoc_rsa is registered state decode: high from the first DONE cycle, low the cycle after clear_rsa is sampled low.
- ena=0 or en_rsa=0 stretches latency cycle-for-cycle, with no state lost.
- rst mid-operation: next cycle is IDLE, out_data=0, eoc_rsa=0.
- clear_rsa=0 mid-operation: IDLE next cycle, out_data unchanged.

## Configuration
- RSA_LZ_SKIP_EN defined: while no set exponent bit has yet been processed, SQ_START/SQ_WAIT are skipped. Each such leading-zero bit costs 1 cycle (NEXT only).
- Latency with the macro: L + 1 + (WIDTH−k) + k·(WIDTH+3) + popcount(e)·(WIDTH+2), where k = position of the MSB set bit + 1 (k=0 for e=0).
- Results are identical with and without the macro.
- Undefined: exact full-length schedule above.

## Structure
- rsa_pkg: state enum typedef, default WIDTH constant. Shared with the enable-logic FSM.
- Sub-module rsa_modmul: Blakley multiplier with mm_start/mm_done handshake, own bit counter, ports clk/rst/ena/clear.
- Top: exponent FSM, acc/idx/operand registers, out_data register.

## Test plan
- WIDTH=8, m=88, e=7, n=187 → out_data=11. eoc_rsa rises exactly 119 cycles after LOAD (69 with RSA_LZ_SKIP_EN).
- m=11, e=23, n=187 → out_data=88; eoc at LOAD+129.
- e=0, n=187, m=5 → out_data=1; eoc at LOAD+89 (LOAD+9 with skip). Then clear_rsa=0 → eoc_rsa=0 next cycle, out_data stays 1.
- Run m=88, e=7, n=187 with en_rsa low for 20 cycles mid-SQ_WAIT → same result, eoc at LOAD+139.
- rst pulse at LOAD+50 → out_data=0, eoc_rsa=0, IDLE. Same with clear_rsa=0 instead: IDLE, out_data keeps its prior value.
- n=0, e=255 → eoc_rsa asserts at LOAD+169 (no hang); value not checked.

Source files
------------

// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA exponentiation core and its enable/sequencing FSM.
package rsa_pkg;
   localparam int RSA_WIDTH = 8;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      SQ_START,
      SQ_WAIT,
      MUL_START,
      MUL_WAIT,
      NEXT,
      DONE
   } rsa_state_e;
endpackage

// File: rtl/rsa_modmul.sv
// Interleaved (Blakley) modular multiplier: product = a*b mod n, MSB-first, one bit per cycle.
// mm_start is sampled at cycle s; mm_done pulses at s+WIDTH+1 with product valid.
module rsa_modmul
   import rsa_pkg::*;
#(
   parameter int WIDTH = RSA_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ena,
   input  logic             clear,
   input  logic             mm_start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] n,
   output logic             mm_done,
   output logic [WIDTH-1:0] product
);
   localparam int PW = WIDTH + 2;
   localparam int CW = $clog2(WIDTH);

   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, n_q, n_d;
   logic [PW-1:0]    p_q, p_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             busy_q, busy_d, done_q, done_d;
   logic [PW-1:0]    p_dbl, p_s1, p_s2, n_ext;

   // 2P + a[i]*b stays below 3n for in-range operands, so two trial subtracts fully reduce it
   always_comb begin
      n_ext = {2'b00, n_q};
      p_dbl = {p_q[PW-2:0], 1'b0} + (a_q[cnt_q] ? {2'b00, b_q} : {PW{1'b0}});
      p_s1  = (p_dbl >= n_ext) ? (p_dbl - n_ext) : p_dbl;
      p_s2  = (p_s1 >= n_ext) ? (p_s1 - n_ext) : p_s1;
   end

   always_comb begin
      a_d    = a_q;
      b_d    = b_q;
      n_d    = n_q;
      p_d    = p_q;
      cnt_d  = cnt_q;
      busy_d = busy_q;
      done_d = 1'b0;
      if (clear) begin
         busy_d = 1'b0;
      end else if (mm_start) begin
         a_d    = a;
         b_d    = b;
         n_d    = n;
         p_d    = '0;
         cnt_d  = CW'(WIDTH - 1);
         busy_d = 1'b1;
      end else if (busy_q) begin
         p_d = p_s2;
         if (cnt_q == '0) begin
            busy_d = 1'b0;
            done_d = 1'b1;
         end else begin
            cnt_d = cnt_q - CW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q    <= '0;
         b_q    <= '0;
         n_q    <= '0;
         p_q    <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else if (ena) begin
         a_q    <= a_d;
         b_q    <= b_d;
         n_q    <= n_d;
         p_q    <= p_d;
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
         done_q <= done_d;
      end
   end

   assign mm_done = done_q;
   assign product = p_q[WIDTH-1:0];
endmodule

// File: rtl/rsa_modexp.sv
// Left-to-right square-and-multiply modular exponentiation (out = in^e mod n).
// Optional macro RSA_LZ_SKIP_EN skips the squarings for leading-zero exponent bits.
module rsa_modexp
   import rsa_pkg::*;
#(
   parameter int WIDTH = RSA_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ena,
   input  logic             en_rsa,
   input  logic             clear_rsa,
   input  logic [WIDTH-1:0] in_data,
   input  logic [WIDTH-1:0] exponent,
   input  logic [WIDTH-1:0] modulus,
   output logic [WIDTH-1:0] out_data,
   output logic             eoc_rsa
);
   localparam int IW = $clog2(WIDTH);

   rsa_state_e       state_q, state_d;
   logic [WIDTH-1:0] m_q, m_d, e_q, e_d, n_q, n_d;
   logic [WIDTH-1:0] acc_q, acc_d, out_q, out_d;
   logic [IW-1:0]    idx_q, idx_d;
`ifdef RSA_LZ_SKIP_EN
   logic             started_q, started_d;
`endif

   logic             mm_ena, mm_clear, mm_start, mm_done;
   logic [WIDTH-1:0] mm_b, mm_product;

   // The multiplier freezes with the FSM on en_rsa=0, but a clear must still reach it
   assign mm_ena   = ena & (en_rsa | ~clear_rsa);
   assign mm_clear = ~clear_rsa;
   assign mm_start = (state_q == SQ_START) || (state_q == MUL_START);
   assign mm_b     = (state_q == MUL_START) ? m_q : acc_q;

   rsa_modmul #(
      .WIDTH(WIDTH)
   ) u_modmul (
      .clk     (clk),
      .rst     (rst),
      .ena     (mm_ena),
      .clear   (mm_clear),
      .mm_start(mm_start),
      .a       (acc_q),
      .b       (mm_b),
      .n       (n_q),
      .mm_done (mm_done),
      .product (mm_product)
   );

   always_comb begin
      state_d = state_q;
      m_d     = m_q;
      e_d     = e_q;
      n_d     = n_q;
      acc_d   = acc_q;
      idx_d   = idx_q;
      out_d   = out_q;
`ifdef RSA_LZ_SKIP_EN
      started_d = started_q;
`endif
      if (!clear_rsa) begin
         state_d = IDLE;
      end else if (en_rsa) begin
         case (state_q)
            IDLE: state_d = LOAD;
            LOAD: begin
               m_d   = in_data;
               e_d   = exponent;
               n_d   = modulus;
               acc_d = WIDTH'(1);
               idx_d = IW'(WIDTH - 1);
`ifdef RSA_LZ_SKIP_EN
               started_d = exponent[WIDTH-1];
               state_d   = exponent[WIDTH-1] ? SQ_START : NEXT;
`else
               state_d = SQ_START;
`endif
            end
            SQ_START: state_d = SQ_WAIT;
            SQ_WAIT: begin
               if (mm_done) begin
                  acc_d   = mm_product;
                  state_d = e_q[idx_q] ? MUL_START : NEXT;
               end
            end
            MUL_START: state_d = MUL_WAIT;
            MUL_WAIT: begin
               if (mm_done) begin
                  acc_d   = mm_product;
                  state_d = NEXT;
               end
            end
            NEXT: begin
               if (idx_q == '0) begin
                  out_d   = acc_q;
                  state_d = DONE;
               end else begin
                  idx_d = idx_q - IW'(1);
`ifdef RSA_LZ_SKIP_EN
                  // acc is still 1 until the first set bit, so squaring it is a no-op
                  if (!started_q && !e_q[idx_d]) begin
                     state_d = NEXT;
                  end else begin
                     started_d = 1'b1;
                     state_d   = SQ_START;
                  end
`else
                  state_d = SQ_START;
`endif
               end
            end
            DONE:    state_d = DONE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         m_q     <= '0;
         e_q     <= '0;
         n_q     <= '0;
         acc_q   <= '0;
         idx_q   <= '0;
         out_q   <= '0;
`ifdef RSA_LZ_SKIP_EN
         started_q <= 1'b0;
`endif
      end else if (ena) begin
         state_q <= state_d;
         m_q     <= m_d;
         e_q     <= e_d;
         n_q     <= n_d;
         acc_q   <= acc_d;
         idx_q   <= idx_d;
         out_q   <= out_d;
`ifdef RSA_LZ_SKIP_EN
         started_q <= started_d;
`endif
      end
   end

   assign out_data = out_q;
   assign eoc_rsa  = (state_q == DONE);
endmodule

// File: tb/tb_rsa_modexp.sv
// Self-checking bench for rsa_modexp: table of fixed and random vectors plus control corner cases.
module tb_rsa_modexp;
   localparam int W = 8;
   localparam int NVEC = 14;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         ena = 1'b1;
   logic         en_rsa = 1'b0;
   logic         clear_rsa = 1'b1;
   logic [W-1:0] in_data = '0;
   logic [W-1:0] exponent = '0;
   logic [W-1:0] modulus = '0;
   logic [W-1:0] out_data;
   logic         eoc_rsa;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   typedef struct {
      int m;
      int e;
      int n;
      int exp_out;
      int exp_lat;
   } vec_t;

   vec_t vecs[NVEC];

   always #5 clk = ~clk;

   rsa_modexp #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst      (rst),
      .ena      (ena),
      .en_rsa   (en_rsa),
      .clear_rsa(clear_rsa),
      .in_data  (in_data),
      .exponent (exponent),
      .modulus  (modulus),
      .out_data (out_data),
      .eoc_rsa  (eoc_rsa)
   );

   // Reference result by repeated multiplication, independent of square-and-multiply
   function automatic int ref_modexp(int m, int e, int n);
      longint r = 1;
      for (int i = 0; i < e; i++) r = (r * m) % n;
      return int'(r);
   endfunction

   function automatic int ref_latency(int e);
      int pop = 0;
      int k = 0;
      for (int i = 0; i < W; i++) begin
         if (e[i]) begin
            pop++;
            k = i + 1;
         end
      end
`ifdef RSA_LZ_SKIP_EN
      return 1 + (W - k) + k * (W + 3) + pop * (W + 2);
`else
      if (k < 0) return -2;
      return 1 + W * (W + 3) + pop * (W + 2);
`endif
   endfunction

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   task automatic clear_to_idle();
      @(negedge clk);
      en_rsa    = 1'b0;
      clear_rsa = 1'b0;
      @(negedge clk);
      clear_rsa = 1'b1;
   endtask

   // Called at a negedge with the DUT in IDLE; returns at the negedge of the LOAD cycle
   task automatic start_op(input int m, input int e, input int n);
      in_data   = W'(m);
      exponent  = W'(e);
      modulus   = W'(n);
      clear_rsa = 1'b1;
      en_rsa    = 1'b1;
      @(posedge clk);
      @(negedge clk);
      cyc = 0;
   endtask

   task automatic wait_eoc(output int lat);
      lat = -1;
      while (cyc < 3000) begin
         step();
         if (eoc_rsa) begin
            lat = cyc;
            break;
         end
      end
   endtask

   initial begin
      int lat;
      int n;
      int m;
      int e;
      int prev_out;

      vecs[0] = '{88, 7, 187, 11, 0};
      vecs[1] = '{11, 23, 187, 88, 0};
      vecs[2] = '{5, 0, 187, 1, 0};
`ifdef RSA_LZ_SKIP_EN
      vecs[0].exp_lat = 69;
      vecs[1].exp_lat = 99;
      vecs[2].exp_lat = 9;
`else
      vecs[0].exp_lat = 119;
      vecs[1].exp_lat = 129;
      vecs[2].exp_lat = 89;
`endif
      for (int i = 3; i < NVEC; i++) begin
         n = int'($urandom_range(2, 255));
         m = int'($urandom_range(0, n - 1));
         e = (i == 3) ? 255 : (i == 4) ? 1 : int'($urandom_range(0, 255));
         vecs[i] = '{m, e, n, ref_modexp(m, e, n), ref_latency(e)};
      end

      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("reset_out", int'(out_data), 0);
      check("reset_eoc", int'(eoc_rsa), 0);

      for (int i = 0; i < NVEC; i++) begin
         clear_to_idle();
         start_op(vecs[i].m, vecs[i].e, vecs[i].n);
         wait_eoc(lat);
         $display("txn vec%0d m=%0d e=%0d n=%0d out=%0d exp=%0d lat=%0d exp_lat=%0d",
                  i, vecs[i].m, vecs[i].e, vecs[i].n, out_data, vecs[i].exp_out, lat, vecs[i].exp_lat);
         check($sformatf("vec%0d_out", i), int'(out_data), vecs[i].exp_out);
         check($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
      end

      // DONE is sticky, then clear drops eoc but keeps the result
      clear_to_idle();
      start_op(5, 0, 187);
      wait_eoc(lat);
      step();
      step();
      check("done_hold_eoc", int'(eoc_rsa), 1);
      clear_rsa = 1'b0;
      step();
      clear_rsa = 1'b1;
      $display("txn clear_after_done eoc=%0d out=%0d", eoc_rsa, out_data);
      check("clear_eoc", int'(eoc_rsa), 0);
      check("clear_keeps_out", int'(out_data), 1);

      // en_rsa low for 20 cycles inside the first SQ_WAIT
      clear_to_idle();
      start_op(88, 7, 187);
      repeat (3) step();
      en_rsa = 1'b0;
      repeat (20) step();
      check("stall_no_eoc", int'(eoc_rsa), 0);
      en_rsa = 1'b1;
      wait_eoc(lat);
      $display("txn en_stall out=%0d lat=%0d", out_data, lat);
      check("en_stall_out", int'(out_data), 11);
      check("en_stall_lat", lat, ref_latency(7) + 20);

      // global ena low for 7 cycles later in the run
      clear_to_idle();
      start_op(11, 23, 187);
      repeat (40) step();
      ena = 1'b0;
      repeat (7) step();
      ena = 1'b1;
      wait_eoc(lat);
      $display("txn ena_stall out=%0d lat=%0d", out_data, lat);
      check("ena_stall_out", int'(out_data), 88);
      check("ena_stall_lat", lat, ref_latency(23) + 7);

      // async reset mid-operation, then a run straight from the reset IDLE state
      clear_to_idle();
      start_op(88, 7, 187);
      repeat (50) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      $display("txn rst_mid out=%0d eoc=%0d", out_data, eoc_rsa);
      check("rst_mid_out", int'(out_data), 0);
      check("rst_mid_eoc", int'(eoc_rsa), 0);
      start_op(88, 7, 187);
      wait_eoc(lat);
      check("after_rst_out", int'(out_data), 11);
      check("after_rst_lat", lat, ref_latency(7));

      // clear mid-operation keeps the previous result
      prev_out = int'(out_data);
      clear_to_idle();
      start_op(11, 23, 187);
      repeat (50) step();
      clear_rsa = 1'b0;
      step();
      clear_rsa = 1'b1;
      $display("txn clear_mid out=%0d eoc=%0d", out_data, eoc_rsa);
      check("clear_mid_out", int'(out_data), prev_out);
      check("clear_mid_eoc", int'(eoc_rsa), 0);
      start_op(11, 23, 187);
      wait_eoc(lat);
      check("after_clear_out", int'(out_data), 88);
      check("after_clear_lat", lat, ref_latency(23));

      // modulus 0 must still terminate on schedule
      clear_to_idle();
      start_op(37, 255, 0);
      wait_eoc(lat);
      $display("txn n_zero lat=%0d", lat);
      check("n_zero_lat", lat, 169);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
